// File: rtl/br_dump_pkg.sv
// Shared definitions for the RV32I register bank and its sequential debug reader.
package br_dump_pkg;

    // Register bank geometry shared by BR and br_dump
    localparam int BR_NREG = 32;
    localparam int BR_AW   = 5;
    localparam int BR_DW   = 32;

    // Dump walker states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_SEND0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_FIN   = 3'd4
    } dump_state_t;

    // Odd partner of an even register address (low bit forced to one)
    function automatic logic [BR_AW-1:0] pair_odd(input logic [BR_AW-1:0] even_addr);
        return {even_addr[BR_AW-1:1], 1'b1};
    endfunction

    // Next even pair index
    function automatic logic [BR_AW-1:0] pair_next(input logic [BR_AW-1:0] even_addr);
        return even_addr + BR_AW'(2);
    endfunction

endpackage

// File: rtl/br_dump_if.sv
// Valid/ready word stream carrying one register value and its index.
interface br_dump_if
    import br_dump_pkg::*;
#(
    parameter int AW = BR_AW,
    parameter int DW = BR_DW
) ();

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;

    // Producer side (br_dump)
    modport master (
        output valid,
        output data,
        output addr,
        input  ready
    );

    // Consumer side (debug / trace sink)
    modport slave (
        input  valid,
        input  data,
        input  addr,
        output ready
    );

endinterface

// File: rtl/br_dump.sv
// Sequential debug reader for the register bank: walks all registers in
// even/odd pairs through BR's two asynchronous read ports and streams each
// value with its index. Every output is driven straight from a register.
module br_dump
    import br_dump_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [BR_AW-1:0] o_a1,
    output logic [BR_AW-1:0] o_a2,
    input  logic [BR_DW-1:0] i_rd1,
    input  logic [BR_DW-1:0] i_rd2,
    output logic             o_busy,
    output logic             o_done,
    br_dump_if.master        o_stream
);

    // Index of the last pair; the walk ends after its odd word is accepted
    localparam logic [BR_AW-1:0] LAST_IDX = BR_AW'(BR_NREG - 2);

    dump_state_t      r_state;
    logic [BR_AW-1:0] r_idx;
    logic [BR_AW-1:0] r_a1;
    logic [BR_AW-1:0] r_a2;
    logic [BR_DW-1:0] r_buf1;
    logic [BR_DW-1:0] r_out_data;
    logic [BR_AW-1:0] r_out_addr;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_ready;
    logic [BR_AW-1:0] w_idx_odd;
    logic [BR_AW-1:0] w_idx_next;

    assign w_ready    = o_stream.ready;
    assign w_idx_odd  = pair_odd(r_idx);
    assign w_idx_next = pair_next(r_idx);

    // Walker FSM: the even word of a pair is captured directly into the output
    // data register (it is the first thing sent), the odd word waits in r_buf1.
    // Read addresses follow idx for the whole dump and are parked at 0 in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= {BR_AW{1'b0}};
            r_a1        <= {BR_AW{1'b0}};
            r_a2        <= {BR_AW{1'b0}};
            r_buf1      <= {BR_DW{1'b0}};
            r_out_data  <= {BR_DW{1'b0}};
            r_out_addr  <= {BR_AW{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_idx   <= {BR_AW{1'b0}};
                        r_a1    <= {BR_AW{1'b0}};
                        r_a2    <= BR_AW'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end else begin
                        r_a1    <= {BR_AW{1'b0}};
                        r_a2    <= {BR_AW{1'b0}};
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_READ: begin
                    // Snapshot of the pair: later BR writes do not affect it
                    r_out_data  <= i_rd1;
                    r_buf1      <= i_rd2;
                    r_out_addr  <= r_idx;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_SEND0;
                end

                ST_SEND0: begin
                    if (w_ready) begin
                        r_out_data <= r_buf1;
                        r_out_addr <= w_idx_odd;
                        r_state    <= ST_SEND1;
                    end else begin
                        r_state    <= ST_SEND0;
                    end
                end

                ST_SEND1: begin
                    if (w_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= {BR_DW{1'b0}};
                        r_out_addr  <= {BR_AW{1'b0}};
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_a1    <= w_idx_next;
                            r_a2    <= pair_odd(w_idx_next);
                            r_state <= ST_READ;
                        end
                    end else begin
                        r_state <= ST_SEND1;
                    end
                end

                ST_FIN: begin
                    // start in this cycle is deliberately not looked at
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_a1    <= {BR_AW{1'b0}};
                    r_a2    <= {BR_AW{1'b0}};
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_idx       <= {BR_AW{1'b0}};
                    r_a1        <= {BR_AW{1'b0}};
                    r_a2        <= {BR_AW{1'b0}};
                    r_out_valid <= 1'b0;
                    r_out_data  <= {BR_DW{1'b0}};
                    r_out_addr  <= {BR_AW{1'b0}};
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign o_a1           = r_a1;
    assign o_a2           = r_a2;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_stream.valid = r_out_valid;
    assign o_stream.data  = r_out_data;
    assign o_stream.addr  = r_out_addr;

endmodule

// File: tb/tb_br_dump.sv
// Directed bench for br_dump with a behavioural register bank and stream sink.
module tb_br_dump;
    import br_dump_pkg::*;

    localparam int H_NONE    = 0;
    localparam int H_RESTART = 1;
    localparam int H_FIN     = 2;
    localparam int H_RST     = 3;
    localparam int H_WRITE   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  a1, a2;
    logic [31:0] rd1, rd2;
    logic        busy, done;

    logic        br_clr, br_we;
    logic [4:0]  br_waddr;
    logic [31:0] br_wdata;
    logic [31:0] br_mem [0:31];

    br_dump_if u_if ();

    br_dump u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .o_a1     (a1),
        .o_a2     (a2),
        .i_rd1    (rd1),
        .i_rd2    (rd2),
        .o_busy   (busy),
        .o_done   (done),
        .o_stream (u_if.master)
    );

    always #5 clk = ~clk;

    // Register bank model: async reads, x0 hardwired to zero, sync write port
    assign rd1 = (a1 == 5'd0) ? 32'd0 : br_mem[a1];
    assign rd2 = (a2 == 5'd0) ? 32'd0 : br_mem[a2];

    always @(posedge clk) begin
        if (br_clr) begin
            for (int i = 0; i < 32; i++) br_mem[i] <= 32'd0;
        end else if (br_we && (br_waddr != 5'd0)) begin
            br_mem[br_waddr] <= br_wdata;
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          cap_n, stall_n, done_n, done_cyc, viol_n;
    logic [4:0]  cap_addr [0:63];
    logic [31:0] cap_data [0:63];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_addr;
    logic [31:0] exp_mem    [0:31];
    logic [31:0] exp_stream [0:31];
    logic [15:0] lfsr = 16'hACE1;

    task automatic clear_mon();
        cap_n = 0; stall_n = 0; done_n = 0; done_cyc = -1; viol_n = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cap_addr[i] = 5'bxxxxx;
            cap_data[i] = 32'hxxxxxxxx;
        end
    endtask

    // Sample the sink side mid-cycle, then advance to just after the next edge
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            if (prev_stall && (u_if.valid !== 1'b1 || u_if.data !== prev_data || u_if.addr !== prev_addr))
                viol_n++;
            prev_stall = u_if.valid && !u_if.ready;
            prev_data  = u_if.data;
            prev_addr  = u_if.addr;
            if (u_if.valid && u_if.ready) begin
                if (cap_n < 64) begin
                    cap_addr[cap_n] = u_if.addr;
                    cap_data[cap_n] = u_if.data;
                end
                cap_n++;
            end
            if (u_if.valid && !u_if.ready) stall_n++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic br_write(input logic [4:0] addr, input logic [31:0] data);
        br_we = 1'b1; br_waddr = addr; br_wdata = data;
        step();
        br_we = 1'b0;
        if (addr != 5'd0) exp_mem[addr] = data;
    endtask

    task automatic load_expected();
        for (int i = 0; i < 32; i++) exp_stream[i] = exp_mem[i];
    endtask

    function automatic int count_bad();
        int b = 0;
        if (cap_n != 32) b++;
        for (int i = 0; i < 32; i++)
            if (cap_addr[i] !== 5'(i) || cap_data[i] !== exp_stream[i]) b++;
        return b;
    endfunction

    // Launch a dump and run it to done (or budget); mode 1 applies LFSR backpressure
    task automatic run_dump(input int mode, input int budget, input int hook);
        int  k = 0;
        int  rel;
        bit  pulsed = 1'b0;
        clear_mon();
        u_if.ready = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        while (done_n == 0 && k < budget) begin
            rel = cyc - start_cyc;
            if (mode == 1) begin
                u_if.ready = lfsr[0];
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end else begin
                u_if.ready = 1'b1;
            end
            start = 1'b0;
            br_we = 1'b0;
            case (hook)
                H_RESTART: if (cap_n == 7 && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
                H_FIN:     start = (rel == 49);
                H_RST:     rst = (rel == 15);
                H_WRITE: begin
                    if (rel == 8) begin br_we = 1'b1; br_waddr = 5'd30; br_wdata = 32'hDEADBEEF; end
                    if (rel == 9) begin br_we = 1'b1; br_waddr = 5'd4;  br_wdata = 32'h0BAD0004; end
                end
                default: ;
            endcase
            step();
            k++;
            if (hook == H_RST && rst) break;
        end
        start = 1'b0;
        br_we = 1'b0;
        u_if.ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; br_clr = 1'b1; start = 1'b1; u_if.ready = 1'b1;
        step(); step();
        br_clr = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %0h expected 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %0h expected 0", done); end
        checks++; if (u_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h expected 0", u_if.valid); end
        checks++; if (u_if.data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h expected 0", u_if.data); end
        checks++; if (u_if.addr !== 5'd0)  begin errors++; $display("FAIL reset_addr got %0h expected 0", u_if.addr); end
        checks++; if (a1 !== 5'd0 || a2 !== 5'd0) begin errors++; $display("FAIL reset_a1a2 got %0h/%0h expected 0/0", a1, a2); end
        rst = 1'b0;
        step();
        run_dump(0, 200, H_NONE);
        step(); step(); step();
        load_expected();
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL zero_dump_words bad %0d expected 0 (count %0d)", count_bad(), cap_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL zero_dump_done_count got %0d expected 1", done_n); end
        checks++; if (done_cyc - start_cyc !== 49) begin errors++; $display("FAIL zero_dump_latency got %0d expected 49", done_cyc - start_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_dump_idle_busy got %0h expected 0", busy); end
    endtask

    task automatic test_known_contents();
        br_write(5'd10, 32'h00000012);
        br_write(5'd5,  32'h0000F00F);
        br_write(5'd21, 32'h00000ABC);
        br_write(5'd0,  32'hFFFFFFFF);
        run_dump(0, 200, H_NONE);
        load_expected();
        checks++; if (cap_data[10] !== 32'h00000012) begin errors++; $display("FAIL known_x10 got %0h expected 12", cap_data[10]); end
        checks++; if (cap_data[5] !== 32'h0000F00F)  begin errors++; $display("FAIL known_x5 got %0h expected f00f", cap_data[5]); end
        checks++; if (cap_data[21] !== 32'h00000ABC) begin errors++; $display("FAIL known_x21 got %0h expected abc", cap_data[21]); end
        checks++; if (cap_data[0] !== 32'd0)         begin errors++; $display("FAIL known_x0 got %0h expected 0", cap_data[0]); end
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL known_words bad %0d expected 0", count_bad()); end
    endtask

    task automatic test_backpressure();
        run_dump(1, 600, H_NONE);
        load_expected();
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL bp_words bad %0d expected 0 (count %0d)", count_bad(), cap_n); end
        checks++; if (viol_n !== 0) begin errors++; $display("FAIL bp_stable violations %0d expected 0", viol_n); end
        checks++; if (stall_n < 1) begin errors++; $display("FAIL bp_stalls got %0d expected >0", stall_n); end
        checks++; if (done_cyc - start_cyc !== 49 + stall_n) begin errors++; $display("FAIL bp_latency got %0d expected %0d", done_cyc - start_cyc, 49 + stall_n); end
    endtask

    task automatic test_start_while_busy();
        run_dump(0, 200, H_RESTART);
        step(); step(); step(); step();
        load_expected();
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL restart_words bad %0d expected 0 (count %0d)", count_bad(), cap_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL restart_done_count got %0d expected 1", done_n); end
        checks++; if (done_cyc - start_cyc !== 49) begin errors++; $display("FAIL restart_latency got %0d expected 49", done_cyc - start_cyc); end
    endtask

    task automatic test_start_in_fin();
        run_dump(0, 200, H_FIN);
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_start_busy got %0h expected 0", busy); end
        checks++; if (cap_n !== 32) begin errors++; $display("FAIL fin_start_count got %0d expected 32", cap_n); end
    endtask

    task automatic test_back_to_back();
        run_dump(0, 200, H_NONE);
        run_dump(0, 200, H_NONE);
        load_expected();
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL b2b_words bad %0d expected 0", count_bad()); end
        checks++; if (done_cyc - start_cyc !== 49) begin errors++; $display("FAIL b2b_latency got %0d expected 49", done_cyc - start_cyc); end
    endtask

    task automatic test_reset_mid_dump();
        run_dump(0, 200, H_RST);
        checks++; if (busy !== 1'b0 || u_if.valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_outputs got busy %0h valid %0h done %0h expected 0 0 0", busy, u_if.valid, done); end
        checks++; if (a1 !== 5'd0 || a2 !== 5'd0 || u_if.addr !== 5'd0 || u_if.data !== 32'd0) begin errors++; $display("FAIL midrst_ports got a1 %0h a2 %0h addr %0h data %0h expected zeros", a1, a2, u_if.addr, u_if.data); end
        checks++; if (cap_n !== 9) begin errors++; $display("FAIL midrst_partial got %0d expected 9", cap_n); end
        rst = 1'b0;
        step(); step(); step();
        checks++; if (done_n !== 0) begin errors++; $display("FAIL midrst_no_done got %0d expected 0", done_n); end
        run_dump(0, 200, H_NONE);
        load_expected();
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL midrst_redump bad %0d expected 0", count_bad()); end
    endtask

    task automatic test_write_during_dump();
        br_write(5'd4, 32'h44444444);
        load_expected();
        exp_stream[30] = 32'hDEADBEEF;
        run_dump(0, 200, H_WRITE);
        checks++; if (cap_data[30] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x30 got %0h expected deadbeef", cap_data[30]); end
        checks++; if (cap_data[4] !== 32'h44444444)  begin errors++; $display("FAIL wr_x4_old got %0h expected 44444444", cap_data[4]); end
        checks++; if (count_bad() !== 0) begin errors++; $display("FAIL wr_words bad %0d expected 0", count_bad()); end
        exp_mem[30] = 32'hDEADBEEF;
        exp_mem[4]  = 32'h0BAD0004;
        run_dump(0, 200, H_NONE);
        load_expected();
        checks++; if (cap_data[4] !== 32'h0BAD0004) begin errors++; $display("FAIL wr_x4_new got %0h expected bad0004", cap_data[4]); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; br_clr = 1'b1; br_we = 1'b0;
        br_waddr = 5'd0; br_wdata = 32'd0; u_if.ready = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
        clear_mon();
        #1;
        test_reset();
        test_known_contents();
        test_backpressure();
        test_start_while_busy();
        test_start_in_fin();
        test_back_to_back();
        test_reset_mid_dump();
        test_write_during_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
